dmem_responder: RTL and testbench

Responder end of the core's load/store data-memory interface: accepts one load or store request at a time over a valid/ready handshake, applies byte/half/word lane selection and sign/zero extension per the access mode, and returns a response after a fixed, parameterised latency. It replaces the zero-latency data memory behind the core's ALU-address/rdata2/rdata path with a multi-cycle, error-reporting memory slave that a stalling core or bus bridge can drive.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_lane_unit.sv | 69 ++++++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: access modes, FSM states and
// the funct3 legality check used by the responder and future bus bridges.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_e;

    function automatic logic mem_mode_legal(input logic [2:0] mode);
        logic legal;
        case (mode)
            MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between a core (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_mode;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_mode, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_mode, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic: store merge with byte enables, load lane
// selection with sign/zero extension, and alignment check.
module dmem_lane_unit
    import mem_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] wr_word,
    output logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        misalign
);
    logic [31:0] lane_data_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = word[{addr_lo, 3'b000} +: 8];
    assign half_s = addr_lo[1] ? word[31:16] : word[15:0];

    // Lane decode: touched bytes, store data replicated onto every lane, alignment
    always_comb begin
        byte_en     = 4'b0000;
        lane_data_s = wdata;
        misalign    = 1'b0;
        case (mode)
            MEM_B, MEM_BU: begin
                byte_en     = 4'b0001 << addr_lo;
                lane_data_s = {4{wdata[7:0]}};
            end
            MEM_H, MEM_HU: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data_s = {2{wdata[15:0]}};
                misalign    = addr_lo[0];
            end
            MEM_W: begin
                byte_en  = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                byte_en     = 4'b0000;
                lane_data_s = wdata;
                misalign    = 1'b0;
            end
        endcase
    end

    // Read-modify-write merge: only enabled lanes take the new data
    always_comb begin
        wr_word = word;
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = byte_en[i] ? lane_data_s[8*i +: 8] : word[8*i +: 8];
        end
    end

    // Load extension by mode
    always_comb begin
        rdata = 32'h0000_0000;
        case (mode)
            MEM_B:   rdata = {{24{byte_s[7]}}, byte_s};
            MEM_BU:  rdata = {24'h00_0000, byte_s};
            MEM_H:   rdata = {{16{half_s[15]}}, half_s};
            MEM_HU:  rdata = {16'h0000, half_s};
            MEM_W:   rdata = word;
            default: rdata = 32'h0000_0000;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then
// commits the store or captures the load and holds the response until consumed.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    rsp_state_e       state_r, state_s;
    logic [3:0]       cnt_r, cnt_s;
    logic             accept_s, commit_s;
    logic             we_r;
    logic [31:0]      addr_r, wdata_r;
    logic [2:0]       mode_r;
    logic             cur_we_s;
    logic [31:0]      cur_addr_s, cur_wdata_s;
    logic [2:0]       cur_mode_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      word_s, wr_word_s, ld_data_s;
    logic [3:0]       byte_en_s;
    logic             misalign_s, err_s;
    logic [31:0]      rdata_r;
    logic             err_r;
    logic [31:0]      mem_r [DEPTH_WORDS];

    // With LATENCY=1 the commit happens on the accept edge, so use the live request there
    always_comb begin
        if (state_r == IDLE) begin
            cur_we_s    = bus.req_we;
            cur_addr_s  = bus.req_addr;
            cur_mode_s  = bus.req_mode;
            cur_wdata_s = bus.req_wdata;
        end else begin
            cur_we_s    = we_r;
            cur_addr_s  = addr_r;
            cur_mode_s  = mode_r;
            cur_wdata_s = wdata_r;
        end
    end

    assign idx_s  = cur_addr_s[IDX_W+1:2];
    assign word_s = mem_r[idx_s];
    assign err_s  = !mem_mode_legal(cur_mode_s) || misalign_s
                 || ({2'b00, cur_addr_s[31:2]} >= 32'(DEPTH_WORDS))
                 || (cur_we_s && cur_mode_s[2]);

    dmem_lane_unit u_lane (
        .mode     (cur_mode_s),
        .addr_lo  (cur_addr_s[1:0]),
        .wdata    (cur_wdata_s),
        .word     (word_s),
        .wr_word  (wr_word_s),
        .byte_en  (byte_en_s),
        .rdata    (ld_data_s),
        .misalign (misalign_s)
    );

    // Next-state and counter logic
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (LATENCY == 1) begin
                        state_s  = RESP;
                        cnt_s    = 4'd0;
                        commit_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_s == 4'd0) begin
                    state_s  = RESP;
                    commit_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, wait counter and latched request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            mode_r  <= 3'b000;
            wdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                we_r    <= bus.req_we;
                addr_r  <= bus.req_addr;
                mode_r  <= bus.req_mode;
                wdata_r <= bus.req_wdata;
            end
        end
    end

    // Response registers, loaded on the commit edge and held while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else if (commit_s) begin
            err_r   <= err_s;
            rdata_r <= (err_s || cur_we_s) ? 32'h0000_0000 : ld_data_s;
        end
    end

    // Word array; deliberately not reset, and writes are blocked while rst is asserted
    always_ff @(posedge clk) begin
        if (rst && commit_s && cur_we_s && !err_s && (byte_en_s != 4'b0000)) begin
            mem_r[idx_s] <= wr_word_s;
        end
    end

    assign bus.req_ready = (state_r == IDLE);
    assign bus.rsp_valid = (state_r == RESP);
    assign bus.rsp_rdata = rdata_r;
    assign bus.rsp_err   = err_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 2, 1, 3)
// checked against a byte-array reference model.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 1024;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  mode;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } dir_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] mdl_a [0:4*DEPTH-1];

    dir_t dir_tbl [16] = '{
        '{1'b1, 32'h10,   3'b010, 32'hDEADBEEF, 32'h0,        1'b0},
        '{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEADBEEF, 1'b0},
        '{1'b1, 32'h11,   3'b000, 32'hABCDEF80, 32'h0,        1'b0},
        '{1'b0, 32'h11,   3'b000, 32'h0,        32'hFFFFFF80, 1'b0},
        '{1'b0, 32'h11,   3'b100, 32'h0,        32'h00000080, 1'b0},
        '{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEAD80EF, 1'b0},
        '{1'b0, 32'h13,   3'b001, 32'h0,        32'h0,        1'b1},
        '{1'b1, 32'h12,   3'b010, 32'h11111111, 32'h0,        1'b1},
        '{1'b0, 32'h10,   3'b011, 32'h0,        32'h0,        1'b1},
        '{1'b0, 32'h1000, 3'b010, 32'h0,        32'h0,        1'b1},
        '{1'b1, 32'h10,   3'b100, 32'h000000FF, 32'h0,        1'b1},
        '{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEAD80EF, 1'b0},
        '{1'b1, 32'h12,   3'b001, 32'h12348001, 32'h0,        1'b0},
        '{1'b0, 32'h12,   3'b001, 32'h0,        32'hFFFF8001, 1'b0},
        '{1'b0, 32'h12,   3'b101, 32'h0,        32'h00008001, 1'b0},
        '{1'b0, 32'h10,   3'b010, 32'h0,        32'h800180EF, 1'b0}
    };

    always #5 clk = ~clk;

    dmem_responder_if if_a ();
    dmem_responder_if if_b ();
    dmem_responder_if if_c ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    // Reference model: byte-addressed little-endian memory with the fault rules
    task automatic model_a(input logic we, input logic [31:0] addr, input logic [2:0] mode,
                           input logic [31:0] wdata, output logic [31:0] exp_rdata, output logic exp_err);
        int     size;
        longint val;
        size      = (mode[1:0] == 2'd0) ? 1 : ((mode[1:0] == 2'd1) ? 2 : 4);
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        if (mode == 3'd3 || mode == 3'd6 || mode == 3'd7) exp_err = 1'b1;
        if ((addr % size) != 0) exp_err = 1'b1;
        if ((addr / 4) >= DEPTH) exp_err = 1'b1;
        if (we && mode >= 3'd4) exp_err = 1'b1;
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mdl_a[addr + i] = 8'(wdata >> (8 * i));
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val += longint'(mdl_a[addr + i]) << (8 * i);
                if (mode < 3'd4 && size < 4 && val >= (64'sd1 <<< (8 * size - 1)))
                    val -= (64'sd1 <<< (8 * size));
                exp_rdata = 32'(val);
            end
        end
    endtask

    task automatic req_a(input logic we, input logic [31:0] addr, input logic [2:0] mode, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        if_a.req_valid = 1'b1; if_a.req_we = we; if_a.req_addr = addr;
        if_a.req_mode = mode; if_a.req_wdata = wdata;
        guard = 0;
        while (!if_a.req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        if_a.req_valid = 1'b0; if_a.req_we = ~we; if_a.req_addr = $urandom;
        if_a.req_mode = 3'($urandom); if_a.req_wdata = $urandom;
        lat = 1;
        while (!if_a.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rdata = if_a.rsp_rdata; err = if_a.rsp_err;
        if_a.rsp_ready = 1'b1; @(posedge clk); #1; if_a.rsp_ready = 1'b0;
    endtask

    task automatic req_c(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
        if_c.req_valid = 1'b1; if_c.req_we = we; if_c.req_addr = addr;
        if_c.req_mode = 3'b010; if_c.req_wdata = wdata;
        @(posedge clk); #1;
        if_c.req_valid = 1'b0;
        lat = 1;
        while (!if_c.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rdata = if_c.rsp_rdata; err = if_c.rsp_err;
        if_c.rsp_ready = 1'b1; @(posedge clk); #1; if_c.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({if_a.rsp_valid, if_a.req_ready, if_a.rsp_err, if_a.rsp_rdata} !== {3'b010, 32'h0}) begin
            n_fail++; $display("FAIL reset_a got v/r/e/d=%b%b%b %h exp 010 0", if_a.rsp_valid, if_a.req_ready, if_a.rsp_err, if_a.rsp_rdata);
        end
        n_checks++;
        if ({if_b.rsp_valid, if_b.req_ready, if_b.rsp_err, if_b.rsp_rdata} !== {3'b010, 32'h0}) begin
            n_fail++; $display("FAIL reset_b got v/r/e/d=%b%b%b %h exp 010 0", if_b.rsp_valid, if_b.req_ready, if_b.rsp_err, if_b.rsp_rdata);
        end
        n_checks++;
        if ({if_c.rsp_valid, if_c.req_ready, if_c.rsp_err, if_c.rsp_rdata} !== {3'b010, 32'h0}) begin
            n_fail++; $display("FAIL reset_c got v/r/e/d=%b%b%b %h exp 010 0", if_c.rsp_valid, if_c.req_ready, if_c.rsp_err, if_c.rsp_rdata);
        end
    endtask

    task automatic test_directed();
        logic [31:0] got, mexp;
        logic        gerr, merr;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            req_a(dir_tbl[i].we, dir_tbl[i].addr, dir_tbl[i].mode, dir_tbl[i].wdata, got, gerr, lat);
            model_a(dir_tbl[i].we, dir_tbl[i].addr, dir_tbl[i].mode, dir_tbl[i].wdata, mexp, merr);
            n_checks++;
            if (got !== dir_tbl[i].rdata || gerr !== dir_tbl[i].err) begin
                n_fail++; $display("FAIL directed[%0d] got data=%h err=%b exp data=%h err=%b", i, got, gerr, dir_tbl[i].rdata, dir_tbl[i].err);
            end
            n_checks++;
            if (lat !== 2) begin
                n_fail++; $display("FAIL latency_dir[%0d] got=%0d exp=2", i, lat);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] hold_d, exp_d, got;
        logic        hold_e, exp_e, gerr;
        int          guard, lat;
        if_a.req_valid = 1'b1; if_a.req_we = 1'b0; if_a.req_addr = 32'h10;
        if_a.req_mode = 3'b010; if_a.req_wdata = 32'h0;
        @(posedge clk); #1;
        if_a.req_valid = 1'b0;
        guard = 0;
        while (!if_a.rsp_valid && guard < 40) begin @(posedge clk); #1; guard++; end
        hold_d = if_a.rsp_rdata; hold_e = if_a.rsp_err;
        model_a(1'b0, 32'h10, 3'b010, 32'h0, exp_d, exp_e);
        n_checks++;
        if (hold_d !== exp_d || hold_e !== exp_e || if_a.rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_first got v=%b d=%h e=%b exp v=1 d=%h e=%b", if_a.rsp_valid, hold_d, hold_e, exp_d, exp_e);
        end
        if_a.req_valid = 1'b1; if_a.req_we = 1'b1; if_a.req_wdata = 32'h0BADF00D;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({if_a.rsp_valid, if_a.req_ready, if_a.rsp_err, if_a.rsp_rdata} !== {2'b10, exp_e, exp_d}) begin
                n_fail++; $display("FAIL stall_hold[%0d] got v/r/e/d=%b%b%b %h exp 10%b %h", k, if_a.rsp_valid, if_a.req_ready, if_a.rsp_err, if_a.rsp_rdata, exp_e, exp_d);
            end
        end
        if_a.req_valid = 1'b0; if_a.rsp_ready = 1'b1;
        @(posedge clk); #1;
        if_a.rsp_ready = 1'b0;
        req_a(1'b0, 32'h10, 3'b010, 32'h0, got, gerr, lat);
        n_checks++;
        if (got !== exp_d || gerr !== 1'b0) begin
            n_fail++; $display("FAIL stall_no_accept got=%h exp=%h", got, exp_d);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, mexp, addr, wd;
        logic        gerr, merr, we;
        logic [2:0]  mode;
        int          lat;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            req_a(1'b1, 32'(w * 4), 3'b010, wd, got, gerr, lat);
            model_a(1'b1, 32'(w * 4), 3'b010, wd, mexp, merr);
            n_checks++;
            if (got !== mexp || gerr !== merr) begin
                n_fail++; $display("FAIL rand_init[%0d] got d=%h e=%b exp d=%h e=%b", w, got, gerr, mexp, merr);
            end
        end
        for (int k = 0; k < 80; k++) begin
            we   = 1'($urandom_range(0, 1));
            mode = 3'($urandom_range(0, 7));
            wd   = $urandom;
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_1000;
            else addr = 32'($urandom_range(0, 63));
            req_a(we, addr, mode, wd, got, gerr, lat);
            model_a(we, addr, mode, wd, mexp, merr);
            n_checks++;
            if (got !== mexp || gerr !== merr || lat !== 2) begin
                n_fail++; $display("FAIL rand[%0d] we=%b mode=%b addr=%h got d=%h e=%b lat=%0d exp d=%h e=%b lat=2", k, we, mode, addr, got, gerr, lat, mexp, merr);
            end
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] got;
        logic        gerr, seen;
        int          lat;
        req_c(1'b1, 32'h20, 32'h7, got, gerr, lat);
        n_checks++;
        if (lat !== 3 || gerr !== 1'b0) begin
            n_fail++; $display("FAIL lat3_store got lat=%0d e=%b exp lat=3 e=0", lat, gerr);
        end
        if_c.req_valid = 1'b1; if_c.req_we = 1'b1; if_c.req_addr = 32'h20;
        if_c.req_mode = 3'b010; if_c.req_wdata = 32'h1;
        @(posedge clk); #1;
        if_c.req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_checks++;
        if (if_c.rsp_valid !== 1'b0 || if_c.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait got v=%b r=%b exp v=0 r=1", if_c.rsp_valid, if_c.req_ready);
        end
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; seen = seen | if_c.rsp_valid; end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL rst_phantom got rsp_valid=%b exp 0", seen);
        end
        req_c(1'b0, 32'h20, 32'h0, got, gerr, lat);
        n_checks++;
        if (got !== 32'h7 || gerr !== 1'b0) begin
            n_fail++; $display("FAIL rst_discard got=%h exp=00000007", got);
        end
        req_c(1'b1, 32'h20, 32'h5, got, gerr, lat);
        req_c(1'b0, 32'h20, 32'h0, got, gerr, lat);
        n_checks++;
        if (got !== 32'h5 || gerr !== 1'b0 || lat !== 3) begin
            n_fail++; $display("FAIL rst_after got=%h lat=%0d exp=00000005 lat=3", got, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        logic [31:0] exp_q [$];
        int          idx, got_n, last_acc;
        logic        acc;
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        idx = 0; got_n = 0; last_acc = -1;
        if_b.rsp_ready = 1'b1;
        if_b.req_valid = 1'b1; if_b.req_we = 1'b1; if_b.req_addr = 32'h0;
        if_b.req_mode = 3'b010; if_b.req_wdata = words[0];
        for (int n = 0; n < 60 && (idx < 8 || got_n < 8); n++) begin
            if (if_b.rsp_valid) begin
                got_n++;
                n_checks++;
                if (exp_q.size() == 0 || if_b.rsp_rdata !== exp_q[0] || if_b.rsp_err !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_rsp[%0d] got d=%h e=%b", got_n, if_b.rsp_rdata, if_b.rsp_err);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            acc = if_b.req_valid && if_b.req_ready;
            if (acc) begin
                if (last_acc >= 0) begin
                    n_checks++;
                    if (n - last_acc !== 2) begin
                        n_fail++; $display("FAIL b2b_spacing got=%0d exp=2", n - last_acc);
                    end
                end
                last_acc = n;
                exp_q.push_back(if_b.req_we ? 32'h0 : words[if_b.req_addr[3:2]]);
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 8) begin
                    if_b.req_we    = (idx < 4);
                    if_b.req_addr  = 32'((idx % 4) * 4);
                    if_b.req_wdata = (idx < 4) ? words[idx] : $urandom;
                end else begin
                    if_b.req_valid = 1'b0;
                end
            end
        end
        if_b.rsp_ready = 1'b0;
        n_checks++;
        if (got_n !== 8 || idx !== 8) begin
            n_fail++; $display("FAIL b2b_count got rsp=%0d acc=%0d exp 8 8", got_n, idx);
        end
    endtask

    initial begin
        if_a.req_valid = 1'b0; if_a.req_we = 1'b0; if_a.req_addr = 32'h0; if_a.req_mode = 3'b0; if_a.req_wdata = 32'h0; if_a.rsp_ready = 1'b0;
        if_b.req_valid = 1'b0; if_b.req_we = 1'b0; if_b.req_addr = 32'h0; if_b.req_mode = 3'b0; if_b.req_wdata = 32'h0; if_b.rsp_ready = 1'b0;
        if_c.req_valid = 1'b0; if_c.req_we = 1'b0; if_c.req_addr = 32'h0; if_c.req_mode = 3'b0; if_c.req_wdata = 32'h0; if_c.rsp_ready = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
